// File: rtl/divider_arbiter_pkg.sv
// Package: divider_arbiter_pkg
// Purpose: shared types and constants for the divider arbiter.
//   state_t        FSM encoding (IDLE -> START -> BUSY -> RESP -> IDLE)
//   DIV0_Q_FILL    fill bit for the quotient returned by the divide-by-zero
//                  bypass (quotient is all ones, remainder is the dividend)
package divider_arbiter_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic DIV0_Q_FILL = 1'b1;

endpackage

// File: rtl/divider_arbiter_picker.sv
// Module: rr_priority_picker
// Purpose: combinational round-robin pick. Scans req upward starting at
//   ptr+1 (wrapping) and returns the first set bit.
// Ports:
//   req    in  NUM_REQ  request vector
//   ptr    in  IDW      index of the previous winner
//   grant  out NUM_REQ  one-hot winner (all zero when req == 0)
//   index  out IDW      binary index of the winner (0 when req == 0)
module rr_priority_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDW-1:0]     ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDW-1:0]     index
);

  logic found;

  // NOTE: every output of a combinational block gets a default before the
  // conditional logic, so no path leaves it unassigned and no latch appears.
  always_comb begin
    grant = '0;
    index = '0;
    found = 1'b0;
    // Offsets 1..NUM_REQ put the previous winner last in the scan order.
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
        found = 1'b1;
        grant[(int'(ptr) + k) % NUM_REQ] = 1'b1;
        index = IDW'((int'(ptr) + k) % NUM_REQ);
      end
    end
  end

endmodule

// File: rtl/divider_arbiter.sv
// Module: divider_arbiter
// Purpose: shares one multi-cycle divider among NUM_REQ requesters. A
//   round-robin winner is picked in IDLE, its operands are latched, the
//   divider is loaded with a one-cycle div_start pulse, the FSM waits for
//   div_dne and then returns quotient/remainder with a one-cycle ack.
// Configuration:
//   DIVIDER_ARBITER_DIV0_BYPASS_EN  when defined, a winner with b == 0 skips
//     the divider: RESP follows the grant directly with rsp_q = all ones and
//     rsp_r = a, and div_start does not pulse. When undefined, b == 0 is
//     sent through the divider like any other operation.
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   req               per-requester request level, held until ack
//   req_a, req_b      packed dividends/divisors, requester i at [i*WIDTH +: WIDTH]
//   ack               one-hot, one-cycle response strobe
//   rsp_q, rsp_r      quotient/remainder, valid while |ack
//   rsp_id            index of acked requester, valid while |ack
//   busy              high whenever the FSM is not in IDLE
//   div_a, div_b      latched operands to the divider
//   div_start         one-cycle load/start pulse to the divider
//   div_ena           divider enable, high in START and BUSY
//   div_q, div_r      divider results
//   div_dne           divider done
module divider_arbiter
  import divider_arbiter_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 32,
  parameter int IDW     = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic [NUM_REQ-1:0]         ack,
  output logic [WIDTH-1:0]           rsp_q,
  output logic [WIDTH-1:0]           rsp_r,
  output logic [IDW-1:0]             rsp_id,
  output logic                       busy,
  output logic [WIDTH-1:0]           div_a,
  output logic [WIDTH-1:0]           div_b,
  output logic                       div_start,
  output logic                       div_ena,
  input  logic [WIDTH-1:0]           div_q,
  input  logic [WIDTH-1:0]           div_r,
  input  logic                       div_dne
);

  state_t               state;
  logic [IDW-1:0]       ptr;
  logic [IDW-1:0]       id_q;
  logic [NUM_REQ-1:0]   grant_q;

  logic [NUM_REQ-1:0]   pick_grant;
  logic [IDW-1:0]       pick_idx;
  logic [WIDTH-1:0]     pick_a;
  logic [WIDTH-1:0]     pick_b;

  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .IDW     (IDW)
  ) u_picker (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .index (pick_idx)
  );

  assign pick_a = req_a[int'(pick_idx)*WIDTH +: WIDTH];
  assign pick_b = req_b[int'(pick_idx)*WIDTH +: WIDTH];

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: only a handful of flops exist here, so all of them (operand
      // and result registers included) are reset to a known zero state.
      state     <= S_IDLE;
      ptr       <= IDW'(NUM_REQ - 1);   // requester 0 wins first
      id_q      <= '0;
      grant_q   <= '0;
      div_a     <= '0;
      div_b     <= '0;
      div_start <= 1'b0;
      div_ena   <= 1'b0;
      busy      <= 1'b0;
      ack       <= '0;
      rsp_q     <= '0;
      rsp_r     <= '0;
      rsp_id    <= '0;
    end else begin
      // Strobes default low and are raised only in the cycle before they
      // must be visible.
      div_start <= 1'b0;
      ack       <= '0;

      case (state)
        S_IDLE: begin
          if (|req) begin
            // Operands are captured here only; later req_a/req_b changes
            // cannot disturb the operation in flight.
            ptr     <= pick_idx;
            id_q    <= pick_idx;
            grant_q <= pick_grant;
            div_a   <= pick_a;
            div_b   <= pick_b;
            busy    <= 1'b1;
`ifdef DIVIDER_ARBITER_DIV0_BYPASS_EN
            if (pick_b == '0) begin
              rsp_q  <= {WIDTH{DIV0_Q_FILL}};
              rsp_r  <= pick_a;
              rsp_id <= pick_idx;
              ack    <= pick_grant;
              state  <= S_RESP;
            end else begin
              div_start <= 1'b1;
              div_ena   <= 1'b1;
              state     <= S_START;
            end
`else
            div_start <= 1'b1;
            div_ena   <= 1'b1;
            state     <= S_START;
`endif
          end
        end

        // div_dne still reflects the previous operation during the load
        // cycle, so it is not looked at until BUSY.
        S_START: begin
          state <= S_BUSY;
        end

        S_BUSY: begin
          if (div_dne) begin
            rsp_q   <= div_q;
            rsp_r   <= div_r;
            rsp_id  <= id_q;
            ack     <= grant_q;
            div_ena <= 1'b0;
            state   <= S_RESP;
          end
        end

        S_RESP: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end

        default: begin
          busy    <= 1'b0;
          div_ena <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Testbench: tb_divider_arbiter
// Directed test of divider_arbiter with a behavioural multi-cycle signed
// divider attached to the div_* ports.
module tb_divider_arbiter;

  localparam int NUM_REQ = 4;
  localparam int WIDTH   = 32;
  localparam int IDW     = 2;
  localparam int LAT     = 5;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ*WIDTH-1:0] req_a;
  logic [NUM_REQ*WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]       ack;
  logic [WIDTH-1:0]         rsp_q;
  logic [WIDTH-1:0]         rsp_r;
  logic [IDW-1:0]           rsp_id;
  logic                     busy;
  logic [WIDTH-1:0]         div_a;
  logic [WIDTH-1:0]         div_b;
  logic                     div_start;
  logic                     div_ena;
  logic [WIDTH-1:0]         div_q;
  logic [WIDTH-1:0]         div_r;
  logic                     div_dne;

  int checks = 0;
  int errors = 0;
  int starts = 0;

  divider_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .IDW     (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .req_a     (req_a),
    .req_b     (req_b),
    .ack       (ack),
    .rsp_q     (rsp_q),
    .rsp_r     (rsp_r),
    .rsp_id    (rsp_id),
    .busy      (busy),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_start (div_start),
    .div_ena   (div_ena),
    .div_q     (div_q),
    .div_r     (div_r),
    .div_dne   (div_dne)
  );

  always #5 clk = ~clk;

  // Behavioural divider: loads on div_start, counts LAT enabled cycles,
  // then raises dne and keeps it high until the next load (so a stale dne
  // is present during the arbiter's START cycle).
  int cnt = 0;
  initial begin
    div_q   = '0;
    div_r   = '0;
    div_dne = 1'b0;
  end
  always @(posedge clk) begin
    if (div_start) begin
      starts  <= starts + 1;
      cnt     <= LAT;
      div_dne <= 1'b0;
      if (div_b == '0) begin
        div_q <= '1;
        div_r <= div_a;
      end else begin
        div_q <= $signed(div_a) / $signed(div_b);
        div_r <= $signed(div_a) % $signed(div_b);
      end
    end else if (div_ena && cnt != 0) begin
      cnt <= cnt - 1;
      if (cnt == 1) div_dne <= 1'b1;
    end
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs,
                       input logic [WIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b);
    req_a[i*WIDTH +: WIDTH] = a;
    req_b[i*WIDTH +: WIDTH] = b;
  endtask

  // Returns at the negedge where ack is first seen (or after a bounded wait).
  task automatic wait_ack(output int id, output int cyc);
    id  = -1;
    cyc = 0;
    while (cyc < 100 && id < 0) begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < NUM_REQ; i++)
        if (ack[i] && id < 0) id = i;
    end
    check("ack_seen", {31'b0, |ack}, 32'd1);
  endtask

  // Checks the response in the ack cycle, then that ack lasted one cycle.
  task automatic expect_resp(input int exp_id, input logic [WIDTH-1:0] q,
                             input logic [WIDTH-1:0] r);
    logic [NUM_REQ-1:0] oh;
    oh = '0;
    oh[exp_id] = 1'b1;
    check("ack_onehot", {28'b0, ack}, {28'b0, oh});
    check("rsp_id", {30'b0, rsp_id}, exp_id);
    check("rsp_q", rsp_q, q);
    check("rsp_r", rsp_r, r);
    @(negedge clk);
    check("ack_one_cycle", {28'b0, ack}, 32'd0);
  endtask

  int id, cyc, s0, late_acks;
  logic [WIDTH-1:0] fq [4];
  logic [WIDTH-1:0] fr [4];

  initial begin
    // a = i+10, b = 3: 10/3=3r1, 11/3=3r2, 12/3=4r0, 13/3=4r1
    fq[0] = 3; fr[0] = 1;
    fq[1] = 3; fr[1] = 2;
    fq[2] = 4; fr[2] = 0;
    fq[3] = 4; fr[3] = 1;

    rst   = 1'b1;
    req   = '0;
    req_a = '0;
    req_b = '0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_ack", {28'b0, ack}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_div_start", {31'b0, div_start}, 32'd0);
    check("rst_div_ena", {31'b0, div_ena}, 32'd0);
    check("rst_div_a", div_a, 32'd0);
    check("rst_rsp_q", rsp_q, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Fairness: all four held, expect 0,1,2,3,0
    for (int i = 0; i < NUM_REQ; i++) set_op(i, i + 10, 3);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_ack(id, cyc);
      if (k == 4) req = '0;
      expect_resp(k % 4, fq[k % 4], fr[k % 4]);
    end

    // Contention: req[1] held, req[3] pending -> 1,3,1 (ptr is 0 here)
    set_op(1, 20, 6);
    set_op(3, 50, 7);
    req = 4'b1010;
    wait_ack(id, cyc);
    expect_resp(1, 3, 2);
    wait_ack(id, cyc);
    req = 4'b0010;
    expect_resp(3, 7, 1);
    wait_ack(id, cyc);
    req = '0;
    expect_resp(1, 3, 2);

    // Single op with operand change after grant
    set_op(0, 100, 7);
    s0 = starts;
    req = 4'b0001;
    @(negedge clk);
    check("single_div_start", {31'b0, div_start}, 32'd1);
    check("single_div_ena", {31'b0, div_ena}, 32'd1);
    check("single_busy", {31'b0, busy}, 32'd1);
    check("single_div_a", div_a, 32'd100);
    check("single_div_b", div_b, 32'd7);
    set_op(0, 0, 1);
    wait_ack(id, cyc);
    req = '0;
    expect_resp(0, 14, 2);
    check("single_start_count", starts - s0, 32'd1);
    check("idle_busy", {31'b0, busy}, 32'd0);

    // Signed: -100 / 7 = -14 r -2
    set_op(2, -100, 7);
    req = 4'b0100;
    wait_ack(id, cyc);
    req = '0;
    expect_resp(2, -14, -2);

    // Reset while BUSY
    set_op(0, 1000, 3);
    req = 4'b0001;
    repeat (4) @(negedge clk);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_ack", {28'b0, ack}, 32'd0);
    check("midrst_div_start", {31'b0, div_start}, 32'd0);
    check("midrst_div_ena", {31'b0, div_ena}, 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;
    late_acks = 0;
    repeat (10) begin
      @(negedge clk);
      if (|ack) late_acks++;
    end
    check("no_ack_after_rst", late_acks, 32'd0);
    set_op(0, 9, 2);
    req = 4'b0001;
    wait_ack(id, cyc);
    req = '0;
    expect_resp(0, 4, 1);

    // Divide by zero: a=55, b=0
    set_op(0, 55, 0);
    s0 = starts;
    req = 4'b0001;
    wait_ack(id, cyc);
    req = '0;
    expect_resp(0, 32'hFFFF_FFFF, 55);
`ifdef DIVIDER_ARBITER_DIV0_BYPASS_EN
    check("div0_no_start", starts - s0, 32'd0);
    // Grant edge moves straight to RESP: ack visible one cycle after req.
    check("div0_latency", cyc, 32'd1);
`else
    check("div0_start", starts - s0, 32'd1);
    check("div0_latency", {31'b0, (cyc > LAT)}, 32'd1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
